flap_ctrl: RTL

- Frame-level controller between the camera dark-pixel counter and the game logic.
- Consumes per-frame upper/lower dark-pixel counts and classifies each frame with a margin.
- Filters classifications over consecutive frames.
- Arbitrates between camera-derived and push-button flap requests; issues flap requests to the game engine over a req/ack handshake with cooldown and timeout.

---
 rtl/flap_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/flap_ctrl.sv
// Frame classifier, agree filter and flap request arbiter; vote/bird_flap lag frame_done by 1 cycle, flap_req by 1 more.
// Game engine backpressure is the flap_req/flap_ack handshake, bounded by ACK_TIMEOUT and followed by a cooldown.
module flap_ctrl #(
    parameter int CNT_W        = 15,
    parameter int MARGIN       = 64,
    parameter int AGREE_FRAMES = 3,
    parameter int COOLDOWN_CYC = 2500000,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_done,
    input  logic [CNT_W-1:0] cnt_up,
    input  logic [CNT_W-1:0] cnt_down,
    input  logic             key_n,
    input  logic             flap_ack,
    output logic             flap_req,
    output logic             bird_flap,
    output logic [1:0]       frame_vote,
    output logic             err_timeout
);

    localparam int AGW = $clog2(AGREE_FRAMES + 1);
    localparam int ATW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int CTW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    localparam logic [CNT_W:0] MARGIN_X  = (CNT_W + 1)'(MARGIN);
    localparam logic [AGW-1:0] AGREE_MAX = AGW'(AGREE_FRAMES);
    localparam logic [ATW-1:0] ACK_LOAD  = ATW'(ACK_TIMEOUT - 1);
    localparam logic [CTW-1:0] COOL_LOAD = CTW'(COOLDOWN_CYC - 1);

    localparam logic [1:0] VOTE_HOLD  = 2'b00;
    localparam logic [1:0] VOTE_GLIDE = 2'b01;
    localparam logic [1:0] VOTE_FLAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, ARMED, REQ, COOL} state_t;

    state_t         state_q;
    logic [ATW-1:0] ack_tmr_q;
    logic [CTW-1:0] cool_tmr_q;
    logic           flap_req_q;
    logic           err_q;
    logic           key_pend_q;

    logic           key_s1_q, key_s2_q, key_s3_q;
    logic           press;
    logic [1:0]     frame_vote_q;
    logic [1:0]     cand_q, cand_d;
    logic [AGW-1:0] agree_q, agree_d;
    logic           bird_q, bird_d;

    logic [CNT_W:0] up_x, dn_x;
    logic [1:0]     vote;

    // One extra guard bit keeps count + MARGIN from wrapping at full-scale counts.
    assign up_x  = {1'b0, cnt_up};
    assign dn_x  = {1'b0, cnt_down};
    assign press = key_s3_q & ~key_s2_q;

    always_comb begin
        vote = VOTE_HOLD;
        if (dn_x > up_x + MARGIN_X) begin
            vote = VOTE_FLAP;
        end else if (up_x > dn_x + MARGIN_X) begin
            vote = VOTE_GLIDE;
        end
    end

    always_comb begin
        cand_d  = cand_q;
        agree_d = agree_q;
        bird_d  = bird_q;
        if (frame_done && vote != VOTE_HOLD) begin
            if (vote == cand_q) begin
                if (agree_q != AGREE_MAX) begin
                    agree_d = agree_q + AGW'(1);
                end
            end else begin
                cand_d  = vote;
                agree_d = AGW'(1);
            end
            if (agree_d == AGREE_MAX) begin
                bird_d = (cand_d == VOTE_FLAP);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1_q     <= 1'b1;
            key_s2_q     <= 1'b1;
            key_s3_q     <= 1'b1;
            frame_vote_q <= VOTE_HOLD;
            cand_q       <= VOTE_HOLD;
            agree_q      <= '0;
            bird_q       <= 1'b0;
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            if (!enable) begin
                cand_q  <= VOTE_HOLD;
                agree_q <= '0;
                bird_q  <= 1'b0;
            end else begin
                if (frame_done) begin
                    frame_vote_q <= vote;
                end
                cand_q  <= cand_d;
                agree_q <= agree_d;
                bird_q  <= bird_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ack_tmr_q  <= '0;
            cool_tmr_q <= '0;
            flap_req_q <= 1'b0;
            err_q      <= 1'b0;
            key_pend_q <= 1'b0;
        end else if (!enable) begin
            state_q    <= IDLE;
            flap_req_q <= 1'b0;
            err_q      <= 1'b0;
            key_pend_q <= 1'b0;
        end else begin
            if (press) begin
                key_pend_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    state_q <= ARMED;
                end
                ARMED: begin
                    // A fresh press is served directly; key and camera share one request.
                    if (key_pend_q || press || bird_q) begin
                        state_q    <= REQ;
                        flap_req_q <= 1'b1;
                        key_pend_q <= 1'b0;
                        ack_tmr_q  <= ACK_LOAD;
                    end
                end
                REQ: begin
                    if (flap_ack || ack_tmr_q == '0) begin
                        state_q    <= COOL;
                        flap_req_q <= 1'b0;
                        cool_tmr_q <= COOL_LOAD;
                        if (!flap_ack) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        ack_tmr_q <= ack_tmr_q - ATW'(1);
                    end
                end
                COOL: begin
                    if (cool_tmr_q == '0) begin
                        state_q <= ARMED;
                    end else begin
                        cool_tmr_q <= cool_tmr_q - CTW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign flap_req    = flap_req_q;
    assign bird_flap   = bird_q;
    assign frame_vote  = frame_vote_q;
    assign err_timeout = err_q;

endmodule
